// File: rtl/ext_display_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : exdisp_pkg                                                 |
// | Description : Shared constants for the external 7-segment display        |
// |               controller: digit count, blank pattern, hex segment table  |
// |               and the field positions inside the external write data.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package exdisp_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = $clog2(NUM_DIGITS);

    // Active-low {g,f,e,d,c,b,a}; all ones means every segment is dark.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Entry [n] is the pattern for hex value n; listed from F down to 0 so
    // the packed index lines up with the value.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // Field positions inside ex_wdata.
    localparam int VAL_LSB = 0;
    localparam int DP_BIT  = 4;
    localparam int CLR_BIT = 31;

endpackage : exdisp_pkg
`default_nettype wire

// File: rtl/ext_display_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : ext_display_ctrl_if                                        |
// | Description : External-device write bus from the MEM stage.              |
// |   ex_write  1   write strobe, one cycle per write                        |
// |   ex_ano    2   digit select, 0 = rightmost                              |
// |   ex_wdata  32  [3:0] value, [4] decimal point, [31] clear digit         |
// |   ex_ack    1   one-cycle pulse the cycle after an accepted write        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface ext_display_ctrl_if;

    logic        ex_write;
    logic [1:0]  ex_ano;
    logic [31:0] ex_wdata;
    logic        ex_ack;

    modport master (output ex_write, output ex_ano, output ex_wdata, input  ex_ack);
    modport slave  (input  ex_write, input  ex_ano, input  ex_wdata, output ex_ack);

endinterface : ext_display_ctrl_if
`default_nettype wire

// File: rtl/ext_display_ctrl_hex_to_seg7.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hex_to_seg7                                                |
// | Description : Combinational 4-bit hex value to active-low 7-segment      |
// |               pattern {g,f,e,d,c,b,a}.                                   |
// |   i_val  in  4   hex value                                               |
// |   o_seg  out 7   active-low segment pattern                              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module hex_to_seg7
    import exdisp_pkg::*;
(
    input  wire logic [3:0] i_val,
    output logic      [6:0] o_seg
);

    assign o_seg = SEG_TABLE[i_val];

endmodule : hex_to_seg7
`default_nettype wire

// File: rtl/ext_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ext_display_ctrl                                           |
// | Description : Responder for CPU external writes. Stores one hex digit    |
// |               per write and time-multiplexes a 4-digit 7-segment display.|
// |   clk    in   system clock                                               |
// |   reset  in   asynchronous, active-high reset                            |
// |   exBus  slv  external write bus (ex_write/ex_ano/ex_wdata/ex_ack)       |
// |   an     out  4  digit anodes, active-low, one-hot                        |
// |   seg    out  7  segments {g,f,e,d,c,b,a}, active-low                     |
// |   dp     out  1  decimal point, active-low                                |
// | Parameter   : SCAN_DIV - clk cycles each digit stays lit (2..2^20)       |
// | Build macro : EXT_DISPLAY_DP_EN - store wdata[4] per digit and drive dp; |
// |               when undefined dp is held off.                             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ext_display_ctrl
    import exdisp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
)(
    input  wire logic            clk,
    input  wire logic            reset,
    ext_display_ctrl_if.slave    exBus,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]           seg,
    output logic                 dp
);

    localparam int                CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] c_AN_ONE = NUM_DIGITS'(1);

    logic [NUM_DIGITS-1:0][3:0] r_digVal;
    logic [NUM_DIGITS-1:0]      r_digValid;
    logic [CNT_W-1:0]           r_scanCnt;
    logic [DIGIT_W-1:0]         r_scanIdx;
    logic                       r_ack;
    logic [NUM_DIGITS-1:0]      r_an;
    logic [6:0]                 r_seg;
    logic [6:0]                 w_hexSeg;

    // Bits of the write word that carry no meaning for this device.
    logic w_unusedWdata;
`ifdef EXT_DISPLAY_DP_EN
    assign w_unusedWdata = ^exBus.ex_wdata[30:5];
`else
    assign w_unusedWdata = ^exBus.ex_wdata[30:4];
`endif

    // Digit storage: indexed by the write's digit select, independent of scan.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digVal   <= '0;
            r_digValid <= '0;
        end else if (exBus.ex_write) begin
            if (exBus.ex_wdata[CLR_BIT]) begin
                r_digValid[exBus.ex_ano] <= 1'b0;
            end else begin
                r_digVal[exBus.ex_ano]   <= exBus.ex_wdata[VAL_LSB +: 4];
                r_digValid[exBus.ex_ano] <= 1'b1;
            end
        end
    end

    // Every write is accepted; the ack simply follows the strobe by a cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= exBus.ex_write;
        end
    end

    // Scan timer and digit index; the index wraps naturally at NUM_DIGITS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scanCnt <= '0;
            r_scanIdx <= '0;
        end else if (r_scanCnt == c_CNT_LAST) begin
            r_scanCnt <= '0;
            r_scanIdx <= r_scanIdx + 1'b1;
        end else begin
            r_scanCnt <= r_scanCnt + 1'b1;
        end
    end

    // Single decoder on the scan mux output.
    hex_to_seg7 u_hexToSeg7 (
        .i_val (r_digVal[r_scanIdx]),
        .o_seg (w_hexSeg)
    );

    // Registered display outputs give every pin a clean, glitch-free edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an  <= '1;
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(c_AN_ONE << r_scanIdx);
            r_seg <= r_digValid[r_scanIdx] ? w_hexSeg : SEG_BLANK;
        end
    end

`ifdef EXT_DISPLAY_DP_EN
    logic [NUM_DIGITS-1:0] r_digDp;
    logic                  r_dp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digDp <= '0;
        end else if (exBus.ex_write && !exBus.ex_wdata[CLR_BIT]) begin
            r_digDp[exBus.ex_ano] <= exBus.ex_wdata[DP_BIT];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dp <= 1'b1;
        end else begin
            r_dp <= ~(r_digValid[r_scanIdx] & r_digDp[r_scanIdx]);
        end
    end

    assign dp = r_dp;
`else
    assign dp = 1'b1;
`endif

    assign an           = r_an;
    assign seg          = r_seg;
    assign exBus.ex_ack = r_ack;

endmodule : ext_display_ctrl
`default_nettype wire

// File: tb/tb_ext_display_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ext_display_ctrl                                        |
// | Description : Directed self-checking bench for ext_display_ctrl with     |
// |               SCAN_DIV=4 (each digit lit for 4 cycles).                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ext_display_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int tests;
    int failed;
    int cyc;           // rising edges since reset was released

    logic [6:0] expSeg [4];
    logic       expDp  [4];

    ext_display_ctrl_if exBus ();

    ext_display_ctrl #(.SCAN_DIV(4)) dut (
        .clk   (clk),
        .reset (reset),
        .exBus (exBus),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Digit expected to be lit after the most recent edge (4 cycles per digit).
    function automatic int litDigit();
        return ((cyc - 1) / 4) % 4;
    endfunction

    function automatic int slotPhase();
        return (cyc - 1) % 4;
    endfunction

    task automatic drive(input logic wr, input logic [1:0] ano, input logic [31:0] data);
        exBus.ex_write = wr;
        exBus.ex_ano   = ano;
        exBus.ex_wdata = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 2'd0, 32'h0);
        #2;
        tests++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || exBus.ex_ack !== 1'b0) begin
            failed++;
            $display("FAIL reset_async: an=%b seg=%h dp=%b ack=%b, want 1111 7f 1 0", an, seg, dp, exBus.ex_ack);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || exBus.ex_ack !== 1'b0) begin
            failed++;
            $display("FAIL reset_held: an=%b seg=%h dp=%b ack=%b, want 1111 7f 1 0", an, seg, dp, exBus.ex_ack);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expSeg[i] = 7'h7F;
            expDp[i]  = 1'b1;
        end
    endtask

    task automatic test_scan_idle();
        logic [3:0] expAn;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            expAn = ~(4'b0001 << litDigit());
            tests++;
            if (an !== expAn || seg !== 7'h7F || dp !== 1'b1) begin
                failed++;
                $display("FAIL scan_idle cyc=%0d: an=%b seg=%h dp=%b, want %b 7f 1", cyc, an, seg, dp, expAn);
            end
        end
    endtask

    task automatic test_write_single();
        logic [3:0] expAn;
        drive(1'b1, 2'd2, 32'h0000_0005);
        @(negedge clk);
        tests++;
        if (exBus.ex_ack !== 1'b1) begin
            failed++;
            $display("FAIL ack_single_high: ack=%b, want 1", exBus.ex_ack);
        end
        drive(1'b0, 2'd0, 32'h0);
        @(negedge clk);
        tests++;
        if (exBus.ex_ack !== 1'b0) begin
            failed++;
            $display("FAIL ack_single_low: ack=%b, want 0", exBus.ex_ack);
        end
        expSeg[2] = 7'h12;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            expAn = ~(4'b0001 << litDigit());
            tests++;
            if (an !== expAn || seg !== expSeg[litDigit()] || dp !== expDp[litDigit()]) begin
                failed++;
                $display("FAIL scan_single cyc=%0d: an=%b seg=%h dp=%b, want %b %h %b",
                         cyc, an, seg, dp, expAn, expSeg[litDigit()], expDp[litDigit()]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] expAn;
        drive(1'b1, 2'd0, 32'h0000_0003);
        @(negedge clk);
        tests++;
        if (exBus.ex_ack !== 1'b1) begin
            failed++;
            $display("FAIL ack_b2b_first: ack=%b, want 1", exBus.ex_ack);
        end
        drive(1'b1, 2'd3, 32'h0000_000F);
        @(negedge clk);
        tests++;
        if (exBus.ex_ack !== 1'b1) begin
            failed++;
            $display("FAIL ack_b2b_second: ack=%b, want 1", exBus.ex_ack);
        end
        drive(1'b0, 2'd0, 32'h0);
        @(negedge clk);
        tests++;
        if (exBus.ex_ack !== 1'b0) begin
            failed++;
            $display("FAIL ack_b2b_end: ack=%b, want 0", exBus.ex_ack);
        end
        expSeg[0] = 7'h30;
        expSeg[3] = 7'h0E;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            expAn = ~(4'b0001 << litDigit());
            tests++;
            if (an !== expAn || seg !== expSeg[litDigit()] || dp !== expDp[litDigit()]) begin
                failed++;
                $display("FAIL scan_b2b cyc=%0d: an=%b seg=%h dp=%b, want %b %h %b",
                         cyc, an, seg, dp, expAn, expSeg[litDigit()], expDp[litDigit()]);
            end
        end
    endtask

    task automatic test_clear_and_last_wins();
        logic [3:0] expAn;
        // Start of digit 2's slot so the clear lands while it is lit.
        for (int w = 0; w < 20 && !(litDigit() == 2 && slotPhase() == 0); w++) @(negedge clk);
        tests++;
        if (!(litDigit() == 2 && slotPhase() == 0)) begin
            failed++;
            $display("FAIL wait_digit2: cyc=%0d, digit 2 slot never reached", cyc);
        end
        drive(1'b1, 2'd2, 32'h8000_0000);
        @(negedge clk);
        tests++;
        if (exBus.ex_ack !== 1'b1 || an !== 4'b1011 || seg !== 7'h12) begin
            failed++;
            $display("FAIL clear_plus1: ack=%b an=%b seg=%h, want 1 1011 12", exBus.ex_ack, an, seg);
        end
        drive(1'b0, 2'd0, 32'h0);
        @(negedge clk);
        tests++;
        if (an !== 4'b1011 || seg !== 7'h7F) begin
            failed++;
            $display("FAIL clear_plus2: an=%b seg=%h, want 1011 7f", an, seg);
        end
        expSeg[2] = 7'h7F;
        // Same digit written twice back-to-back: the second value must stick.
        drive(1'b1, 2'd1, 32'h0000_0001);
        @(negedge clk);
        drive(1'b1, 2'd1, 32'h0000_0017);
        @(negedge clk);
        drive(1'b0, 2'd0, 32'h0);
        @(negedge clk);
        expSeg[1] = 7'h78;
`ifdef EXT_DISPLAY_DP_EN
        expDp[1] = 1'b0;
`endif
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            expAn = ~(4'b0001 << litDigit());
            tests++;
            if (an !== expAn || seg !== expSeg[litDigit()] || dp !== expDp[litDigit()]) begin
                failed++;
                $display("FAIL scan_clear cyc=%0d: an=%b seg=%h dp=%b, want %b %h %b",
                         cyc, an, seg, dp, expAn, expSeg[litDigit()], expDp[litDigit()]);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [3:0] expAn;
        for (int w = 0; w < 20 && !(litDigit() == 2 && slotPhase() == 1); w++) @(negedge clk);
        tests++;
        if (an !== 4'b1011) begin
            failed++;
            $display("FAIL mid_slot_an: an=%b, want 1011", an);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1 || exBus.ex_ack !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid: an=%b seg=%h dp=%b ack=%b, want 1111 7f 1 0", an, seg, dp, exBus.ex_ack);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expSeg[i] = 7'h7F;
            expDp[i]  = 1'b1;
        end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            expAn = ~(4'b0001 << litDigit());
            tests++;
            if (an !== expAn || seg !== 7'h7F || dp !== 1'b1) begin
                failed++;
                $display("FAIL scan_after_reset cyc=%0d: an=%b seg=%h dp=%b, want %b 7f 1", cyc, an, seg, dp, expAn);
            end
        end
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        test_reset();
        test_scan_idle();
        test_write_single();
        test_back_to_back();
        test_clear_and_last_wins();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_ext_display_ctrl
`default_nettype wire
